// File: rtl/vga_pixel_engine.sv
// VGA pixel engine: H/V timing, byte command decoder, palette and a serializer
// fed by a one-entry pixel-word buffer with backpressure and underflow flag.
module vga_pixel_engine #(
  parameter int unsigned COLOR_W   = 4,
  parameter int unsigned BPP       = 1,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned H_VISIBLE = 800,
  parameter int unsigned H_FRONT   = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BACK    = 88,
  parameter int unsigned V_VISIBLE = 600,
  parameter int unsigned V_FRONT   = 1,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BACK    = 23,
  parameter bit          HSYNC_POL = 1'b1,
  parameter bit          VSYNC_POL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         cmd_data,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic [15:0]        hcount,
  output logic [15:0]        vcount,
  output logic               frame_start,
  output logic               underflow,
  output logic               bad_cmd
);

  localparam int unsigned PAL_N   = 1 << BPP;
  localparam int unsigned PPW     = WORD_W / BPP;
  localparam int unsigned PH_W    = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int unsigned RGB_W   = 3 * COLOR_W;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [15:0] H_VIS  = 16'(H_VISIBLE);
  localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
  localparam logic [15:0] H_SS   = 16'(H_VISIBLE + H_FRONT);
  localparam logic [15:0] H_SE   = 16'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [15:0] V_VIS  = 16'(V_VISIBLE);
  localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
  localparam logic [15:0] V_SS   = 16'(V_VISIBLE + V_FRONT);
  localparam logic [15:0] V_SE   = 16'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic [7:0]  OP_NOP  = 8'h00;
  localparam logic [7:0]  OP_PIX  = 8'h81;
  localparam logic [7:0]  OP_CLR  = 8'h84;
  localparam logic [7:0]  OP_PAL  = 8'h90;
  localparam logic [7:0]  PAL_END = 8'(144 + PAL_N);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PPW - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARG_PIX,
    ARG_R,
    ARG_G,
    ARG_B
  } state_t;

  state_t state, state_nxt;

  logic [BPP-1:0]     pal_idx;
  logic [COLOR_W-1:0] r_lat;
  logic [COLOR_W-1:0] g_lat;
  logic [RGB_W-1:0]   pal [PAL_N];

  logic               buf_full;
  logic [WORD_W-1:0]  buf_word;
  logic [WORD_W-1:0]  shifter;
  logic [PH_W-1:0]    phase;

  logic               accept_c;
  logic               buf_wr_c;
  logic               pal_wr_c;
  logic               idx_ld_c;
  logic               r_ld_c;
  logic               g_ld_c;
  logic               flag_clr_c;
  logic               bad_set_c;
  logic               vis_c;
  logic               fetch_c;
  logic [BPP-1:0]     pix_c;
  logic [RGB_W-1:0]   rgb_c;

  // Backpressure only while a pixel argument waits on a full buffer.
  assign cmd_ready = !((state == ARG_PIX) && buf_full);
  assign accept_c  = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Decoder next-state and per-byte strobes.
  always_comb begin
    state_nxt  = state;
    buf_wr_c   = 1'b0;
    pal_wr_c   = 1'b0;
    idx_ld_c   = 1'b0;
    r_ld_c     = 1'b0;
    g_ld_c     = 1'b0;
    flag_clr_c = 1'b0;
    bad_set_c  = 1'b0;
    if (accept_c) begin
      case (state)
        IDLE: begin
          if (cmd_data == OP_PIX) begin
            state_nxt = ARG_PIX;
          end else if ((cmd_data >= OP_PAL) && (cmd_data < PAL_END)) begin
            idx_ld_c  = 1'b1;
            state_nxt = ARG_R;
          end else if (cmd_data == OP_CLR) begin
            flag_clr_c = 1'b1;
          end else if (cmd_data != OP_NOP) begin
            bad_set_c = 1'b1;
          end
        end
        ARG_PIX: begin
          buf_wr_c  = 1'b1;
          state_nxt = IDLE;
        end
        ARG_R: begin
          r_ld_c    = 1'b1;
          state_nxt = ARG_G;
        end
        ARG_G: begin
          g_ld_c    = 1'b1;
          state_nxt = ARG_B;
        end
        ARG_B: begin
          pal_wr_c  = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Pixel selection: fresh word at a word boundary, otherwise the shifter.
  always_comb begin
    vis_c   = (hcount < H_VIS) && (vcount < V_VIS);
    fetch_c = vis_c && (phase == '0);
    pix_c   = fetch_c ? buf_word[WORD_W-1 -: BPP] : shifter[WORD_W-1 -: BPP];
    rgb_c   = vis_c ? pal[pix_c] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + 16'd1;
    end else begin
      hcount <= hcount + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= '0;
      shifter <= '0;
    end else if (vis_c) begin
      phase   <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
      shifter <= fetch_c ? (buf_word << BPP) : (shifter << BPP);
    end else begin
      phase <= '0;
    end
  end

  // Buffer: a write always lands after a same-cycle fetch has seen it empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_word <= '0;
    end else if (buf_wr_c) begin
      buf_full <= 1'b1;
      buf_word <= cmd_data[WORD_W-1:0];
    end else if (fetch_c) begin
      buf_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pal_idx <= '0;
      r_lat   <= '0;
      g_lat   <= '0;
      for (int unsigned i = 0; i < PAL_N; i++) pal[i] <= (i == 0) ? '0 : '1;
    end else begin
      if (idx_ld_c) pal_idx <= cmd_data[BPP-1:0];
      if (r_ld_c)   r_lat   <= cmd_data[COLOR_W-1:0];
      if (g_ld_c)   g_lat   <= cmd_data[COLOR_W-1:0];
      if (pal_wr_c) pal[pal_idx] <= {r_lat, g_lat, cmd_data[COLOR_W-1:0]};
    end
  end

  // Sticky flags; the clear opcode wins over a same-cycle set.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow <= 1'b0;
      bad_cmd   <= 1'b0;
    end else if (flag_clr_c) begin
      underflow <= 1'b0;
      bad_cmd   <= 1'b0;
    end else begin
      if (fetch_c && !buf_full) underflow <= 1'b1;
      if (bad_set_c)            bad_cmd   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= ((hcount >= H_SS) && (hcount < H_SE)) ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= ((vcount >= V_SS) && (vcount < V_SE)) ? VSYNC_POL : ~VSYNC_POL;
      red         <= rgb_c[RGB_W-1 -: COLOR_W];
      green       <= rgb_c[2*COLOR_W-1 -: COLOR_W];
      blue        <= rgb_c[COLOR_W-1:0];
      frame_start <= (hcount == '0) && (vcount == '0);
    end
  end

endmodule

// File: tb/tb_vga_pixel_engine.sv
// Bench for vga_pixel_engine: small timing, random command stream checked
// every cycle against a cycle-count based reference model, plus pinned literals.
module tb_vga_pixel_engine;
  localparam int CW = 4, BPP = 2, WW = 8, PPW = WW / BPP, PAL_N = 1 << BPP;
  localparam int HV = 16, HF = 2, HS = 3, HB = 2, HT = HV + HF + HS + HB;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1, VT = VV + VF + VS + VB;
  localparam bit HP = 1'b1, VP = 1'b0;

  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_ready;
  logic [7:0] cmd_data = 8'h00;
  logic hsync, vsync, frame_start, underflow, bad_cmd;
  logic [CW-1:0] red, green, blue;
  logic [15:0] hcount, vcount;

  vga_pixel_engine #(
    .COLOR_W(CW), .BPP(BPP), .WORD_W(WW),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(HP), .VSYNC_POL(VP)
  ) dut (
    .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .hsync(hsync), .vsync(vsync), .red(red),
    .green(green), .blue(blue), .hcount(hcount), .vcount(vcount),
    .frame_start(frame_start), .underflow(underflow), .bad_cmd(bad_cmd)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: position is derived from a cycle count since reset.
  int m_t, m_state, m_full, m_word, m_cur, m_idx, m_r, m_g;
  int pal_r[PAL_N], pal_g[PAL_N], pal_b[PAL_N];
  int e_r, e_g, e_b, e_hs, e_vs, e_fs, e_uf, e_bad;

  always @(posedge clk) begin
    int h, v, p, d;
    bit vis, acc, clr;
    if (rst) begin
      m_t = 0; m_state = 0; m_full = 0; m_word = 0; m_cur = 0;
      for (int i = 0; i < PAL_N; i++) begin
        pal_r[i] = (i == 0) ? 0 : 15; pal_g[i] = pal_r[i]; pal_b[i] = pal_r[i];
      end
      e_r = 0; e_g = 0; e_b = 0; e_hs = !HP; e_vs = !VP; e_fs = 0; e_uf = 0; e_bad = 0;
    end else begin
      h = m_t % HT; v = m_t / HT; vis = (h < HV) && (v < VV);
      d = int'(cmd_data);
      acc = cmd_valid && !(m_state == 1 && m_full == 1);
      clr = 1'b0;
      e_r = 0; e_g = 0; e_b = 0;
      if (vis) begin
        if (h % PPW == 0) begin
          if (m_full == 0) e_uf = 1;
          m_cur = m_word; m_full = 0;
        end
        p = (m_cur >> (WW - BPP * (h % PPW + 1))) & (PAL_N - 1);
        e_r = pal_r[p]; e_g = pal_g[p]; e_b = pal_b[p];
      end
      e_hs = (h >= HV + HF && h < HV + HF + HS) ? HP : !HP;
      e_vs = (v >= VV + VF && v < VV + VF + VS) ? VP : !VP;
      e_fs = (h == 0 && v == 0);
      if (acc) begin
        case (m_state)
          0: if (d == 'h81) m_state = 1;
             else if (d >= 'h90 && d < 'h90 + PAL_N) begin m_idx = d - 'h90; m_state = 2; end
             else if (d == 'h84) clr = 1'b1;
             else if (d != 0) e_bad = 1;
          1: begin m_word = d; m_full = 1; m_state = 0; end
          2: begin m_r = d % 16; m_state = 3; end
          3: begin m_g = d % 16; m_state = 4; end
          default: begin
            pal_r[m_idx] = m_r; pal_g[m_idx] = m_g; pal_b[m_idx] = d % 16; m_state = 0;
          end
        endcase
      end
      if (clr) begin e_uf = 0; e_bad = 0; end
      m_t = (m_t + 1) % (HT * VT);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("hcount", int'(hcount), m_t % HT);
      chk("vcount", int'(vcount), m_t / HT);
      chk("hsync", int'(hsync), e_hs);
      chk("vsync", int'(vsync), e_vs);
      chk("red", int'(red), e_r);
      chk("green", int'(green), e_g);
      chk("blue", int'(blue), e_b);
      chk("frame_start", int'(frame_start), e_fs);
      chk("underflow", int'(underflow), e_uf);
      chk("bad_cmd", int'(bad_cmd), e_bad);
      chk("cmd_ready", int'(cmd_ready), int'(!(m_state == 1 && m_full == 1)));
    end
  end

  task automatic send(input logic [7:0] b, output int stalls);
    int n;
    n = 0;
    cmd_data = b; cmd_valid = 1'b1;
    while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      errors++; checks++;
      $display("FAIL send_timeout byte %0h: got ready 0 expected 1", b);
    end
    stalls = n;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_line(input int line);
    int n;
    n = 0;
    while (int'(vcount) != line && n < 600) begin @(negedge clk); n++; end
    if (n >= 600) begin
      errors++; checks++;
      $display("FAIL wait_line %0d: got vcount %0d expected %0d", line, vcount, line);
    end
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    @(negedge clk);
    while (!frame_start && n < 600) begin @(negedge clk); n++; end
    if (n >= 600) begin
      errors++; checks++;
      $display("FAIL wait_frame_start: got 0 expected 1");
    end
  endtask

  initial begin
    int st, period;
    logic [7:0] b;
    @(posedge clk); @(negedge clk);
    started = 1'b1;
    chk("rst_hcount", int'(hcount), 0);
    chk("rst_hsync", int'(hsync), 0);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_red", int'(red), 0);
    rst = 1'b0;

    // Frame period in cycles.
    wait_fs();
    period = 0;
    do begin @(negedge clk); period++; end while (!frame_start && period < 600);
    chk("frame_period", period, HT * VT);

    // Palette entry 2 and a single word 0x80: one coloured pixel then black.
    wait_line(VV);
    send(8'h92, st); send(8'h0F, st); send(8'h03, st); send(8'h0C, st);
    send(8'h81, st); send(8'h80, st); send(8'h84, st);
    wait_fs();
    chk("pix0_red", int'(red), 15);
    chk("pix0_green", int'(green), 3);
    chk("pix0_blue", int'(blue), 12);
    @(negedge clk);
    chk("pix1_red", int'(red), 0);
    repeat (3) @(negedge clk);
    chk("pix4_reuse_red", int'(red), 15);
    chk("pix4_underflow", int'(underflow), 1);

    // Unknown opcode sets bad_cmd; clear opcode drops it.
    send(8'h97, st);
    chk("bad_set", int'(bad_cmd), 1);
    send(8'h84, st);
    chk("bad_clr", int'(bad_cmd), 0);

    // Backpressure on a second pixel argument while the buffer is full.
    wait_line(VV);
    send(8'h81, st); send(8'h11, st); send(8'h81, st); send(8'h22, st);
    chk("stall_seen", int'(st > 0), 1);

    // Reset between a palette R byte and its G byte.
    send(8'h91, st); send(8'h05, st);
    rst = 1'b1;
    @(negedge clk);
    chk("midcmd_hcount", int'(hcount), 0);
    rst = 1'b0;
    send(8'h07, st);
    chk("midcmd_idle_bad", int'(bad_cmd), 1);

    // Random command stream.
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4: b = 8'h81;
        5, 6, 7:       b = 8'(8'h90 + $urandom_range(0, 5));
        8, 9:          b = 8'h84;
        10:            b = 8'h00;
        default:       b = 8'($urandom);
      endcase
      cmd_data  = b;
      cmd_valid = ($urandom_range(0, 2) == 0);
      rst       = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
